instr_sequencer: RTL and testbench

- Multi-cycle fetch/execute controller for the 9-bit-instruction core.
- Owns the program counter and fetches from instruction memory over a req/ack handshake.
- Presents each instruction to the control decoder and sequences data-memory access for load/store.
- Decides the next PC from the decoder's jump flag and the ALU compare result, and gates register-file writes to a single retire cycle.

---
 rtl/instr_sequencer.sv | 116 +++++++++++
 tb/tb_instr_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute/memory/retire controller for the 9-bit-instruction core
module instr_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [8:0]       imem_rdata,
    output logic [8:0]       inst,
    output logic             exec_en,
    input  logic             branch_flag,
    input  logic             cond_branch,
    input  logic             cmp_true,
    input  logic             mem_to_reg,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic [PC_W-1:0]  target,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted
);
    localparam logic [8:0] HALT_OP = 9'h1FE;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_MEM, S_RETIRE, S_HALT
    } state_t;

    state_t           state;
    logic             take_q;
    logic [PC_W-1:0]  target_q;
    logic             we_q;

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            inst       <= '0;
            imem_req   <= 1'b0;
            exec_en    <= 1'b0;
            dmem_req   <= 1'b0;
            rf_we      <= 1'b0;
            retire_cnt <= '0;
            halted     <= 1'b0;
            take_q     <= 1'b0;
            target_q   <= '0;
            we_q       <= 1'b0;
        end else begin
            exec_en <= 1'b0;
            rf_we   <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc         <= start_pc;
                        retire_cnt <= '0;
                        imem_req   <= 1'b1;
                        halted     <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (imem_rdata == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            inst    <= imem_rdata;
                            exec_en <= 1'b1;
                            state   <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    // A jump and a taken conditional branch share the same target.
                    take_q   <= branch_flag | (cond_branch & cmp_true);
                    target_q <= target;
                    // Load+store together is treated as a store: no register write.
                    we_q     <= reg_write & ~(mem_to_reg & mem_write);
                    if (mem_to_reg || mem_write) begin
                        dmem_req <= 1'b1;
                        state    <= S_MEM;
                    end else begin
                        rf_we <= reg_write;
                        state <= S_RETIRE;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        rf_we    <= we_q;
                        state    <= S_RETIRE;
                    end
                end
                S_RETIRE: begin
                    pc <= take_q ? target_q : pc + 1'b1;
                    if (retire_cnt != '1) begin
                        retire_cnt <= retire_cnt + 1'b1;
                    end
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;
    localparam int PC_W  = 10;
    localparam int CNT_W = 4;
    localparam logic [8:0] HALT_OP = 9'h1FE;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [PC_W-1:0]  start_pc;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [8:0]       imem_rdata;
    logic [8:0]       inst;
    logic             exec_en;
    logic             branch_flag;
    logic             cond_branch;
    logic             cmp_true;
    logic             mem_to_reg;
    logic             mem_write;
    logic             reg_write;
    logic [PC_W-1:0]  target;
    logic             dmem_req;
    logic             dmem_ack;
    logic             rf_we;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] retire_cnt;
    logic             halted;

    instr_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .exec_en(exec_en),
        .branch_flag(branch_flag), .cond_branch(cond_branch), .cmp_true(cmp_true),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .reg_write(reg_write),
        .target(target), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .rf_we(rf_we),
        .pc(pc), .retire_cnt(retire_cnt), .halted(halted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [PC_W-1:0] model_pc;
    int              model_cnt;
    logic [8:0]      model_inst;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_run(input logic [PC_W-1:0] spc);
        start    = 1'b1;
        start_pc = spc;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        model_pc  = spc;
        model_cnt = 0;
        check("start_fetch", imem_req, 1);
        check("start_halted", halted, 0);
        check("start_cnt", retire_cnt, 0);
    endtask

    // fl = {branch_flag, cond_branch, cmp_true, mem_to_reg, mem_write, reg_write}
    task automatic do_instr(input logic [8:0] op, input logic [5:0] fl,
                            input logic [PC_W-1:0] tgt, input int iw, input int dw);
        int cyc = 0, n_ireq = 0, n_exec = 0, n_dreq = 0, n_we = 0, we_at = -1;
        bit addr_ok = 1, inst_ok = 1, timed_out = 0;
        bit is_mem, exp_we, taken;
        int exp_cyc;
        logic [PC_W-1:0] exp_pc;
        is_mem  = fl[2] | fl[1];
        exp_we  = fl[0] && !(fl[2] && fl[1]);
        taken   = fl[5] || (fl[4] && fl[3]);
        exp_pc  = taken ? tgt : model_pc + 10'd1;
        exp_cyc = 3 + iw + (is_mem ? dw + 1 : 0);
        forever begin
            if (cyc > 0 && ((imem_req && n_exec > 0) || halted)) break;
            if (cyc > 400) begin
                timed_out = 1;
                break;
            end
            if (imem_req) begin
                n_ireq++;
                if (imem_addr != model_pc) addr_ok = 0;
            end
            if (exec_en) begin
                n_exec++;
                if (inst != op) inst_ok = 0;
            end
            if (dmem_req) n_dreq++;
            if (rf_we) begin
                n_we++;
                we_at = cyc;
            end
            start      = 1'($urandom);
            start_pc   = PC_W'($urandom);
            imem_ack   = imem_req ? (n_ireq == iw + 1) : 1'($urandom);
            imem_rdata = imem_req ? op : 9'($urandom);
            dmem_ack   = dmem_req ? (n_dreq == dw + 1) : 1'($urandom);
            if (exec_en) begin
                {branch_flag, cond_branch, cmp_true, mem_to_reg, mem_write, reg_write} = fl;
                target = tgt;
            end else begin
                {branch_flag, cond_branch, cmp_true, mem_to_reg, mem_write, reg_write} = 6'($urandom);
                target = PC_W'($urandom);
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("no_timeout", timed_out, 0);
        check("ireq_cycles", n_ireq, iw + 1);
        check("fetch_addr", addr_ok, 1);
        if (op == HALT_OP) begin
            check("halt_flag", halted, 1);
            check("halt_noexec", n_exec, 0);
            check("halt_pc", pc, model_pc);
            check("halt_cnt", retire_cnt, model_cnt);
            check("halt_inst", inst, model_inst);
        end else begin
            check("exec_pulses", n_exec, 1);
            check("inst_latched", inst_ok, 1);
            check("dreq_cycles", n_dreq, is_mem ? dw + 1 : 0);
            check("we_pulses", n_we, exp_we ? 1 : 0);
            if (exp_we) check("we_at_retire", we_at, cyc - 1);
            check("latency", cyc, exp_cyc);
            model_pc   = exp_pc;
            model_cnt  = (model_cnt == (1 << CNT_W) - 1) ? model_cnt : model_cnt + 1;
            model_inst = op;
            check("next_pc", pc, model_pc);
            check("retire_cnt", retire_cnt, model_cnt);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; start_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
        branch_flag = 1'b0; cond_branch = 1'b0; cmp_true = 1'b0; mem_to_reg = 1'b0;
        mem_write = 1'b0; reg_write = 1'b0; target = '0; dmem_ack = 1'b0;
        model_inst = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {imem_req, dmem_req, exec_en, rf_we, halted}, 0);
        check("rst_pc", pc, 0);
        check("rst_cnt", retire_cnt, 0);
        check("rst_inst", inst, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_no_req", imem_req, 0);

        start_run(10'h010);
        do_instr(9'h006, 6'b000001, 10'h0, 0, 0);
        do_instr(HALT_OP, 6'b000000, 10'h0, 1, 0);
        start_run(10'h020);
        do_instr(9'h0A0, 6'b000101, 10'h0, 0, 4);
        do_instr(9'h012, 6'b011000, 10'h100, 0, 0);
        do_instr(9'h012, 6'b010000, 10'h200, 2, 0);
        do_instr(9'h044, 6'b100000, 10'h3FF, 0, 0);
        do_instr(9'h006, 6'b000001, 10'h155, 1, 0);
        check("wrap_pc", pc, 0);
        do_instr(9'h044, 6'b110000, 10'h050, 0, 0);
        do_instr(9'h0B0, 6'b000111, 10'h0, 0, 2);
        do_instr(9'h003, 6'b000000, 10'h0, 0, 0);
        do_instr(HALT_OP, 6'b000000, 10'h0, 0, 0);
        start_run(10'h005);
        do_instr(9'h006, 6'b000001, 10'h0, 0, 0);

        imem_ack = 1'b1; imem_rdata = 9'h0A0;
        @(negedge clk);
        {branch_flag, cond_branch, cmp_true, mem_to_reg, mem_write, reg_write} = 6'b000101;
        imem_ack = 1'b0;
        @(negedge clk);
        check("mid_dreq", dmem_req, 1);
        dmem_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst_dreq", dmem_req, 0);
        check("arst_we", rf_we, 0);
        check("arst_pc", pc, 0);
        check("arst_cnt", retire_cnt, 0);
        check("arst_ireq", imem_req, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_inst = '0;
        @(negedge clk);
        start_run(10'h123);
        do_instr(9'h006, 6'b000001, 10'h0, 1, 0);

        for (int k = 0; k < 200; k++) begin
            logic [8:0] op;
            op = 9'($urandom);
            if ($urandom_range(0, 19) == 0) op = HALT_OP;
            else if (op == HALT_OP) op = 9'h006;
            do_instr(op, 6'($urandom), PC_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            if (halted) start_run(PC_W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
